pc_update_sequencer: RTL and testbench
======================================

Name: pc_update_sequencer

Overview:
- Sequences all program-counter updates through one shared WIDTH-bit CLA adder: sequential increment, PC-relative branch, absolute jump.
- Sits between fetch/branch logic (requesters) and the PC consumer; holds the architectural PC register.
- Presents each new PC with a valid/ack handshake.
- Instantiates the existing nbit_CLA_full_adder (WIDTH) as its only adder; no other arithmetic on the PC path.

Parameters:
- WIDTH, 16, PC width in bits (>= 4).
- STEP, 4, increment amount for inc requests; unsigned; must be < 2^WIDTH.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- inc_req  input  1  request PC <= PC + STEP.
- br_req  input  1  request PC <= PC + br_offset.
- br_offset  input  WIDTH  signed two's-complement branch offset; sampled on acceptance.
- jmp_req  input  1  request PC <= jmp_target.
- jmp_target  input  WIDTH  absolute target; sampled on acceptance.
- stall  input  1  freezes FSM and all registers while high.
- pc_ack  input  1  consumer accepts presented PC.
- pc  output  WIDTH  current PC register.
- pc_valid  output  1  pc holds a newly computed, unacknowledged value.
- busy  output  1  high in every state except IDLE; requests ignored while high.
- wrap  output  1  last update wrapped modulo 2^WIDTH; valid while pc_valid.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, pc=RESET_PC, pc_valid=0, busy=0, wrap=0, operand latch=0.
- States: IDLE, ADD, PRESENT.
- IDLE:
  - Samples requests each unstalled cycle.
  - Priority: jmp_req > br_req > inc_req; lower-priority requests in the same cycle are dropped, not queued.
  - jmp: pc <= jmp_target, wrap <= 0, go to PRESENT (1-cycle latency).
  - br: latch br_offset as adder B operand, go to ADD.
  - inc: latch STEP as adder B operand, go to ADD.
  - No request: stay in IDLE.
- ADD:
  - Adder A = pc, B = latched operand, carry-in 0.
  - Next edge: pc <= sum[WIDTH-1:0], go to PRESENT. Latency for inc/br is 2 cycles from acceptance to pc_valid.
  - wrap for inc = carry-out.
  - wrap for br: carry-out=1 with offset >= 0, or carry-out=0 with offset < 0 (unsigned wrap of PC address space).
  - Result is always truncated modulo 2^WIDTH; no saturation.
- PRESENT:
  - pc_valid=1; pc and wrap held stable until pc_ack sampled high.
  - On ack: pc_valid <= 0, wrap <= 0, go to IDLE; the next request is accepted no earlier than the following cycle.
  - Requests arriving during PRESENT are ignored.
- busy = (state != IDLE), combinational from state.
- stall high: no state, pc, operand or flag change in any state.
  - pc_ack during stall is ignored; the consumer must re-assert it.
  - Requests during stall are ignored.
- Reset mid-operation: in-flight ADD result is discarded and pc returns to RESET_PC.
- Simultaneous stall and request in IDLE: request is not accepted.
- pc_ack while not in PRESENT: ignored.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: on every transition into PRESENT, simulation prints one line containing the source (JMP/BR/INC), old pc, new pc and wrap, all in hex; no change to ports or timing.
- Undefined: no display statements compiled; logic identical.

Test Plan:
- Reset then inc_req pulse, WIDTH=16, STEP=4: pc=0x0000 -> pc_valid high 2 cycles after acceptance with pc=0x0004, wrap=0; pc_ack -> pc_valid=0, busy=0.
- pc=0xFFFE, inc_req -> pc=0x0002, wrap=1; br_offset=0xFFFC (-4) from pc=0x0010 -> pc=0x000C, wrap=0.
- jmp_req, br_req and inc_req high together, jmp_target=0x1234 -> pc=0x1234 after 1 cycle, wrap=0; the br and inc requests have no effect on pc.
- stall high for 3 cycles while in ADD -> pc unchanged and pc_valid=0 during stall; result appears 1 cycle after stall drops. pc_ack held during stall in PRESENT -> pc_valid stays 1.
- reset low asynchronously while in ADD with pc=0x0040 -> pc=RESET_PC and pc_valid=0 immediately, before the next clk edge; the following inc gives RESET_PC+STEP.
- inc_req held high continuously, pc_ack held high -> one update per 3 cycles (IDLE, ADD, PRESENT); busy low exactly one cycle in three.

Source files
------------

// File: rtl/pc_update_sequencer.sv
// pc_update_sequencer: holds the architectural PC and sequences every update
// (increment by STEP, PC-relative branch, absolute jump) through a single
// shared CLA adder, presenting each new PC to the consumer with pc_valid/pc_ack.
//
// Handshake: pc_valid is high exactly while the FSM is in PRESENT; pc and wrap
// are stable for that whole time, and the value is consumed on the first
// rising edge where pc_ack is high and stall is low.
//
// Optional feature: define PC_TRACE_EN to print one line on every entry into
// PRESENT (source, old pc, new pc, wrap). Ports and timing are unaffected.
//
// Also contains nbit_CLA_full_adder, the adder this block instantiates.

module nbit_CLA_full_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry chain from generate/propagate terms.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];
endmodule

module pc_update_sequencer #(
    parameter int               WIDTH    = 16,
    parameter int unsigned      STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_req,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp_req,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             stall,
    input  logic             pc_ack,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             busy,
    output logic             wrap
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADD     = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_OP = WIDTH'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             op_br_q, op_br_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_wrap;

    // The only adder on the PC path: A = current pc, B = latched operand.
    nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (pc_q),
        .b    (operand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Increment wraps on carry-out; a branch wraps when the carry disagrees
    // with the offset sign (positive offset overflowing, or negative offset
    // borrowing below zero).
    assign add_wrap = op_br_q ? (operand_q[WIDTH-1] ? ~add_cout : add_cout)
                              : add_cout;

    // State and datapath registers; stall is folded into the next-state logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            operand_q <= '0;
            op_br_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            operand_q <= operand_d;
            op_br_q   <= op_br_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state and datapath selection; everything holds while stalled.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        operand_d = operand_q;
        op_br_d   = op_br_q;
        wrap_d    = wrap_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (jmp_req) begin
                        pc_d    = jmp_target;
                        wrap_d  = 1'b0;
                        state_d = S_PRESENT;
                    end else if (br_req) begin
                        operand_d = br_offset;
                        op_br_d   = 1'b1;
                        state_d   = S_ADD;
                    end else if (inc_req) begin
                        operand_d = STEP_OP;
                        op_br_d   = 1'b0;
                        state_d   = S_ADD;
                    end
                end
                S_ADD: begin
                    pc_d    = add_sum;
                    wrap_d  = add_wrap;
                    state_d = S_PRESENT;
                end
                S_PRESENT: begin
                    if (pc_ack) begin
                        wrap_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign pc       = pc_q;
    assign wrap     = wrap_q;
    assign pc_valid = (state_q == S_PRESENT);
    assign busy     = (state_q != S_IDLE);

`ifdef PC_TRACE_EN
    // Trace each entry into PRESENT with its source and result.
    always_ff @(posedge clk) begin
        if (reset && !stall && state_q != S_PRESENT && state_d == S_PRESENT) begin
            if (state_q == S_IDLE)
                $display("pc_trace: JMP old=%h new=%h wrap=%h", pc_q, pc_d, wrap_d);
            else if (op_br_q)
                $display("pc_trace: BR old=%h new=%h wrap=%h", pc_q, pc_d, wrap_d);
            else
                $display("pc_trace: INC old=%h new=%h wrap=%h", pc_q, pc_d, wrap_d);
        end
    end
`endif
endmodule

// File: tb/tb_pc_update_sequencer.sv
// Self-checking bench for pc_update_sequencer (WIDTH=16, STEP=4, RESET_PC=0).
// Directed vector table, hand-written multi-cycle sequences, then randomized
// traffic against a transaction-level reference model with an expected queue.

module tb_pc_update_sequencer;
    localparam int W = 16;
    localparam int STEP = 4;
    localparam logic [W-1:0] RST_PC = 16'h0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         inc_req = 1'b0;
    logic         br_req = 1'b0;
    logic [W-1:0] br_offset = '0;
    logic         jmp_req = 1'b0;
    logic [W-1:0] jmp_target = '0;
    logic         stall = 1'b0;
    logic         pc_ack = 1'b0;
    logic [W-1:0] pc;
    logic         pc_valid;
    logic         busy;
    logic         wrap;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    pc_update_sequencer #(.WIDTH(W), .STEP(STEP), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .inc_req    (inc_req),
        .br_req     (br_req),
        .br_offset  (br_offset),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .stall      (stall),
        .pc_ack     (pc_ack),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .busy       (busy),
        .wrap       (wrap)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inc_req = 1'b0; br_req = 1'b0; jmp_req = 1'b0;
        stall = 1'b0; pc_ack = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Wait (bounded) for pc_valid; returns cycles waited including the current one.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!pc_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack_now();
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
    endtask

    task automatic jump_to(input logic [W-1:0] tgt);
        jmp_req = 1'b1; jmp_target = tgt;
        tick();
        jmp_req = 1'b0;
        ack_now();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [W-1:0] start;
        int           op;       // 0 inc, 1 br, 2 jmp
        logic [W-1:0] arg;
        logic [W-1:0] exp_pc;
        logic         exp_wrap;
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx);
        int lat;
        vec_t v;
        v = vecs[idx];
        jump_to(v.start);
        case (v.op)
            0: inc_req = 1'b1;
            1: begin br_req = 1'b1; br_offset = v.arg; end
            default: begin jmp_req = 1'b1; jmp_target = v.arg; end
        endcase
        tick();
        clear_inputs();
        wait_valid(lat);
        chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("vec%0d_pc", idx), pc, v.exp_pc);
        chk($sformatf("vec%0d_wrap", idx), wrap, v.exp_wrap);
        ack_now();
        chk($sformatf("vec%0d_idle", idx), {pc_valid, busy, wrap}, 3'b000);
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_pc;
    logic [W-1:0] m_new;
    logic         m_wrap;
    logic         m_pend;
    int           m_cnt;

    task automatic model_reset();
        m_pc = RST_PC; m_new = RST_PC; m_wrap = 1'b0; m_pend = 1'b0; m_cnt = 0;
    endtask

    // One rising edge worth of behaviour, from the inputs currently driven.
    task automatic model_step();
        longint nv;
        if (!m_pend) begin
            if (!stall && (jmp_req || br_req || inc_req)) begin
                if (jmp_req) begin
                    nv = longint'(jmp_target);
                    m_wrap = 1'b0;
                end else if (br_req) begin
                    nv = longint'(m_pc) + longint'($signed(br_offset));
                    m_wrap = (nv < 0) || (nv >= (64'sd1 << W));
                end else begin
                    nv = longint'(m_pc) + STEP;
                    m_wrap = (nv >= (64'sd1 << W));
                end
                m_new = nv[W-1:0];
                m_pend = 1'b1;
                exp_q.push_back(m_new);
                if (jmp_req) begin
                    m_pc = m_new;
                    m_cnt = 0;
                end else begin
                    m_cnt = 1;
                end
            end
        end else if (m_cnt > 0) begin
            if (!stall) begin
                m_cnt = 0;
                m_pc = m_new;
            end
        end else if (!stall && pc_ack) begin
            m_pend = 1'b0;
        end
    endtask

    // ---------------- main test ----------------
    initial begin
        int lat;
        int busy_low;
        logic [W-1:0] base;
        logic exp_valid;

        vecs[0] = '{16'h0000, 0, 16'h0000, 16'h0004, 1'b0, 2};
        vecs[1] = '{16'hFFFE, 0, 16'h0000, 16'h0002, 1'b1, 2};
        vecs[2] = '{16'h0010, 1, 16'hFFFC, 16'h000C, 1'b0, 2};
        vecs[3] = '{16'h0002, 1, 16'hFFFC, 16'hFFFE, 1'b1, 2};
        vecs[4] = '{16'hFFF0, 1, 16'h0020, 16'h0010, 1'b1, 2};
        vecs[5] = '{16'h1000, 1, 16'h0100, 16'h1100, 1'b0, 2};
        vecs[6] = '{16'hFFFC, 0, 16'h0000, 16'h0000, 1'b1, 2};
        vecs[7] = '{16'h0ABC, 2, 16'h1234, 16'h1234, 1'b0, 1};

        // Reset state.
        #12;
        chk("reset_pc", pc, RST_PC);
        chk("reset_flags", {pc_valid, busy, wrap}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // First inc from reset: 2-cycle latency, then ack returns to idle.
        inc_req = 1'b1;
        tick();
        inc_req = 1'b0;
        chk("first_inc_busy", busy, 1'b1);
        chk("first_inc_not_valid", pc_valid, 1'b0);
        wait_valid(lat);
        chk("first_inc_latency", lat, 2);
        chk("first_inc_pc", pc, 16'h0004);
        ack_now();

        for (int i = 0; i < 8; i++) run_vec(i);

        // All three requests together: jump wins, others dropped.
        jump_to(16'h0100);
        jmp_req = 1'b1; br_req = 1'b1; inc_req = 1'b1;
        jmp_target = 16'h1234; br_offset = 16'h0008;
        tick();
        clear_inputs();
        chk("prio_valid_1cyc", pc_valid, 1'b1);
        chk("prio_pc", pc, 16'h1234);
        chk("prio_wrap", wrap, 1'b0);
        ack_now();
        tick();
        tick();
        chk("prio_no_followup", {busy, pc}, {1'b0, 16'h1234});

        // Stall in ADD for 3 cycles, then ack held during stall in PRESENT.
        inc_req = 1'b1;
        tick();
        inc_req = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_add_hold", {pc_valid, busy, pc}, {1'b0, 1'b1, 16'h1234});
        end
        stall = 1'b0;
        tick();
        chk("stall_add_result", {pc_valid, pc}, {1'b1, 16'h1238});
        stall = 1'b1; pc_ack = 1'b1;
        tick();
        tick();
        chk("stall_ack_ignored", {pc_valid, pc}, {1'b1, 16'h1238});
        stall = 1'b0;
        tick();
        pc_ack = 1'b0;
        chk("ack_after_stall", {pc_valid, busy}, 2'b00);

        // Stall together with a request in IDLE: not accepted.
        stall = 1'b1; inc_req = 1'b1;
        tick();
        stall = 1'b0; inc_req = 1'b0;
        tick();
        chk("stall_req_dropped", {busy, pc}, {1'b0, 16'h1238});

        // Async reset during ADD.
        jump_to(16'h0040);
        inc_req = 1'b1;
        tick();
        inc_req = 1'b0;
        chk("pre_reset_in_add", {busy, pc}, {1'b1, 16'h0040});
        #2 reset = 1'b0;
        #1;
        chk("async_reset_pc", pc, RST_PC);
        chk("async_reset_flags", {pc_valid, busy}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        tick();
        inc_req = 1'b1;
        tick();
        inc_req = 1'b0;
        wait_valid(lat);
        chk("post_reset_inc", pc, RST_PC + 16'(STEP));
        ack_now();

        // Continuous inc with ack held: one update every 3 cycles.
        base = pc;
        busy_low = 0;
        inc_req = 1'b1; pc_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (!busy) busy_low++;
        end
        clear_inputs();
        chk("stream_busy_low", busy_low, 3);
        chk("stream_pc", pc, base + 16'(3 * STEP));

        // Randomized traffic against the reference model.
        reset = 1'b0;
        #3;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int c = 0; c < 1500; c++) begin
            stall      = ($urandom_range(0, 4) == 0);
            jmp_req    = ($urandom_range(0, 5) == 0);
            br_req     = ($urandom_range(0, 2) == 0);
            inc_req    = ($urandom_range(0, 1) == 0);
            pc_ack     = ($urandom_range(0, 2) != 0);
            br_offset  = 16'($urandom);
            jmp_target = 16'($urandom);
            if (pc_valid && pc_ack && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_present", pc, 16'hxxxx);
                end else begin
                    chk("sb_consumed_pc", pc, exp_q.pop_front());
                end
            end
            model_step();
            tick();
            exp_valid = m_pend && (m_cnt == 0);
            chk("rand_pc", pc, m_pc);
            chk("rand_valid", pc_valid, exp_valid);
            chk("rand_busy", busy, m_pend);
            chk("rand_wrap", wrap, exp_valid ? m_wrap : 1'b0);
        end
        clear_inputs();
        chk("sb_queue_depth", exp_q.size(), m_pend ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
